bcd_down_cnt: RTL and testbench

BCD_DOWN_CNT -- requirements
Module: bcd_down_cnt

---
 rtl/bcd_down_cnt.sv | 92 +++++++++
 tb/tb_bcd_down_cnt.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bcd_down_cnt.sv
// bcd_down_cnt -- two-digit BCD down counter with load, enable and borrow.
//
// Ports
//   CK     in   1  clock, all state on rising edge
//   Clear  in   1  synchronous active-high reset (Q=00, Bo=0)
//   Load   in   1  load D (per-digit saturated to 9) on next edge
//   D      in   8  load value, [7:4] tens, [3:0] units
//   En     in   1  decrement by one per edge
//   Q      out  8  registered count, always valid BCD
//   Zero   out  1  combinational, high when Q == 00
//   Bo     out  1  registered borrow, one cycle after a decrement from 00
//
// Parameter WRAP: 1 = 00 wraps to 99 on decrement, 0 = hold at 00.
// Edge priority: Clear > Load > En > hold.

// Per-digit next-state cell. Combinational only; the top owns the flops.
// A digit decrements when a borrow arrives from below; it passes the
// borrow on when it is itself at zero.
module bcd_digit (
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic       dec,
  input  logic [3:0] cur,
  output logic [3:0] nxt,
  output logic       bout
);
  always_comb begin
    bout = dec && (cur == 4'd0);
    nxt  = cur;
    if (load)
      nxt = (ld_val > 4'd9) ? 4'd9 : ld_val;
    else if (dec)
      nxt = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
  end
endmodule

module bcd_down_cnt #(
  parameter bit WRAP = 1'b1
) (
  input  logic       CK,
  input  logic       Clear,
  input  logic       Load,
  input  logic [7:0] D,
  input  logic       En,
  output logic [7:0] Q,
  output logic       Zero,
  output logic       Bo
);
  localparam int NUM_DIGITS = 2;

  logic [NUM_DIGITS-1:0][3:0] q_q, q_d, dig_nxt, ld_dig;
  logic [NUM_DIGITS:0]        brw;
  logic                       bo_q, bo_d;

  assign ld_dig = D;
  // Load masks the decrement so the chain never sees a borrow on load.
  assign brw[0] = En & ~Load;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .load  (Load),
      .ld_val(ld_dig[g]),
      .dec   (brw[g]),
      .cur   (q_q[g]),
      .nxt   (dig_nxt[g]),
      .bout  (brw[g+1])
    );
  end

  // A borrow out of the top digit means En was applied at 00. The digit
  // chain naturally produces 99; without WRAP the count is held instead.
  always_comb begin
    q_d  = dig_nxt;
    bo_d = brw[NUM_DIGITS];
    if (brw[NUM_DIGITS] && !WRAP)
      q_d = q_q;
  end

  always_ff @(posedge CK) begin
    if (Clear) begin
      q_q  <= '0;
      bo_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      bo_q <= bo_d;
    end
  end

  assign Q    = q_q;
  assign Zero = (q_q == '0);
  assign Bo   = bo_q;
endmodule

// File: tb/tb_bcd_down_cnt.sv
module tb_bcd_down_cnt;
  logic       CK = 1'b0;
  logic       Clear = 1'b0, Load = 1'b0, En = 1'b0;
  logic [7:0] D = 8'h00;
  logic [7:0] q_w, q_h;
  logic       zero_w, zero_h, bo_w, bo_h;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 CK = ~CK;

  bcd_down_cnt #(.WRAP(1'b1)) dut_w (
    .CK(CK), .Clear(Clear), .Load(Load), .D(D), .En(En),
    .Q(q_w), .Zero(zero_w), .Bo(bo_w)
  );
  bcd_down_cnt #(.WRAP(1'b0)) dut_h (
    .CK(CK), .Clear(Clear), .Load(Load), .D(D), .En(En),
    .Q(q_h), .Zero(zero_h), .Bo(bo_h)
  );

  // Reference model: count held as a plain integer 0..99.
  function automatic int mnext(int v, bit clr, bit ld, bit en,
                               logic [7:0] d, bit wrap, output bit bo);
    int t, u;
    bo = 1'b0;
    if (clr) return 0;
    if (ld) begin
      t = int'(d[7:4]); u = int'(d[3:0]);
      if (t > 9) t = 9;
      if (u > 9) u = 9;
      return t * 10 + u;
    end
    if (en) begin
      if (v == 0) begin
        bo = 1'b1;
        return wrap ? 99 : 0;
      end
      return v - 1;
    end
    return v;
  endfunction

  function automatic logic [7:0] to_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_all(string tag, logic [7:0] eqw, bit ebw,
                         logic [7:0] eqh, bit ebh);
    chk({tag, " Q(wrap)"},    q_w, eqw);
    chk({tag, " Bo(wrap)"},   {7'd0, bo_w}, {7'd0, ebw});
    chk({tag, " Zero(wrap)"}, {7'd0, zero_w}, {7'd0, eqw == 8'h00});
    chk({tag, " Q(hold)"},    q_h, eqh);
    chk({tag, " Bo(hold)"},   {7'd0, bo_h}, {7'd0, ebh});
    chk({tag, " Zero(hold)"}, {7'd0, zero_h}, {7'd0, eqh == 8'h00});
  endtask

  // Drive away from the edge, then sample 1 time unit after it.
  task automatic step(bit clr, bit ld, bit en, logic [7:0] d);
    @(negedge CK);
    Clear = clr; Load = ld; En = en; D = d;
    @(posedge CK);
    #1;
  endtask

  typedef struct {
    bit clr, ld, en;
    logic [7:0] d;
    logic [7:0] qw; bit bw;
    logic [7:0] qh; bit bh;
  } vec_t;

  vec_t vt[$];

  initial begin
    int mw, mh;
    bit bw, bh;
    bit clr, ld, en;
    logic [7:0] d;

    //          clr ld en d      qw    bw  qh    bh
    vt.push_back('{1, 1, 1, 8'h42, 8'h00, 0, 8'h00, 0}); // clear wins
    vt.push_back('{0, 1, 0, 8'hAF, 8'h99, 0, 8'h99, 0});
    vt.push_back('{0, 1, 0, 8'h5B, 8'h59, 0, 8'h59, 0});
    vt.push_back('{0, 1, 0, 8'h3C, 8'h39, 0, 8'h39, 0});
    vt.push_back('{0, 0, 1, 8'h00, 8'h38, 0, 8'h38, 0});
    vt.push_back('{0, 1, 0, 8'h40, 8'h40, 0, 8'h40, 0});
    vt.push_back('{0, 0, 1, 8'h00, 8'h39, 0, 8'h39, 0}); // tens borrow
    vt.push_back('{0, 1, 0, 8'h30, 8'h30, 0, 8'h30, 0});
    vt.push_back('{0, 1, 1, 8'h75, 8'h75, 0, 8'h75, 0}); // load beats en
    vt.push_back('{0, 0, 1, 8'h00, 8'h74, 0, 8'h74, 0});
    vt.push_back('{0, 1, 0, 8'h68, 8'h68, 0, 8'h68, 0});
    for (int i = 0; i < 5; i++)
      vt.push_back('{0, 0, 0, 8'h11, 8'h68, 0, 8'h68, 0});
    vt.push_back('{0, 1, 0, 8'h57, 8'h57, 0, 8'h57, 0});
    vt.push_back('{1, 0, 1, 8'h00, 8'h00, 0, 8'h00, 0}); // clear mid-count
    vt.push_back('{0, 0, 1, 8'h00, 8'h99, 1, 8'h00, 1});
    vt.push_back('{0, 0, 1, 8'h00, 8'h98, 0, 8'h00, 1});
    vt.push_back('{0, 0, 0, 8'h00, 8'h98, 0, 8'h00, 0});
    vt.push_back('{0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0});
    vt.push_back('{0, 0, 1, 8'h00, 8'h99, 1, 8'h00, 1});
    vt.push_back('{0, 1, 1, 8'h00, 8'h00, 0, 8'h00, 0}); // load at 00 no Bo

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].clr, vt[i].ld, vt[i].en, vt[i].d);
      chk_all($sformatf("vec%0d", i), vt[i].qw, vt[i].bw, vt[i].qh, vt[i].bh);
    end

    // Load 12 and count down 13 edges through the terminal case.
    step(0, 1, 0, 8'h12);
    for (int i = 1; i <= 13; i++) begin
      step(0, 0, 1, 8'h00);
      if (i <= 12)
        chk_all($sformatf("cnt12 e%0d", i), to_bcd(12 - i), 0, to_bcd(12 - i), 0);
      else
        chk_all("cnt12 e13", 8'h99, 1, 8'h00, 1);
    end

    // Non-wrapping counter repeatedly borrowing at 00.
    step(0, 1, 0, 8'h01);
    step(0, 0, 1, 8'h00);
    chk("nowrap e1 Q", q_h, 8'h00); chk("nowrap e1 Bo", {7'd0, bo_h}, 8'h00);
    step(0, 0, 1, 8'h00);
    chk("nowrap e2 Q", q_h, 8'h00); chk("nowrap e2 Bo", {7'd0, bo_h}, 8'h01);
    step(0, 0, 1, 8'h00);
    chk("nowrap e3 Q", q_h, 8'h00); chk("nowrap e3 Bo", {7'd0, bo_h}, 8'h01);
    step(0, 0, 0, 8'h00);
    chk("nowrap idle Bo", {7'd0, bo_h}, 8'h00);

    // Clear raised between edges must not touch Q until an edge.
    step(0, 1, 0, 8'h57);
    @(negedge CK);
    Clear = 1'b1;
    #2;
    chk("clear between edges", q_w, 8'h57);
    Clear = 1'b0;
    step(0, 0, 1, 8'h00);
    chk("resume after clear", q_w, 8'h56);

    // Randomized run against the integer model.
    step(1, 0, 0, 8'h00);
    mw = 0; mh = 0;
    chk_all("rand start", 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 19) == 0);
      ld  = ($urandom_range(0, 4) == 0);
      en  = ($urandom_range(0, 2) != 0);
      d   = 8'($urandom);
      mw = mnext(mw, clr, ld, en, d, 1'b1, bw);
      mh = mnext(mh, clr, ld, en, d, 1'b0, bh);
      step(clr, ld, en, d);
      chk_all($sformatf("rand%0d", i), to_bcd(mw), bw, to_bcd(mh), bh);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
